// File: rtl/lbus_pkg.sv
// Shared definitions for the local-bus initiator: FSM states, default phase
// timing and the responder's register map.
package lbus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    GAP    = 3'd3,
    RESP   = 3'd4
  } lbus_state_e;

  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 3;
  localparam int DEF_GAP_CYC    = 3;
  localparam int DEF_CNT_W      = 4;

  localparam logic [15:0] ADDR_CTRL = 16'h0002;
  localparam logic [15:0] ADDR_ID   = 16'hFFFC;
  localparam logic [15:0] ADDR_DIN  = 16'h0100;
  localparam logic [15:0] ADDR_DOUT = 16'h0180;

  // A polled read keeps going while any masked bit of the captured word is set.
  function automatic logic poll_pending(input logic [15:0] data, input logic [15:0] mask);
    return (data & mask) != 16'h0000;
  endfunction

endpackage

// File: rtl/lbus_master.sv
// Local-bus initiator: one valid/ready command becomes one timed write or read
// cycle on lbus_*, answered by one response. Optional polled reads: LBUS_POLL_EN.
module lbus_master
  import lbus_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [15:0] lbus_a,
  output logic [15:0] lbus_di,
  output logic        lbus_wr,
  output logic        lbus_rd,
  input  logic [15:0] lbus_do
`ifdef LBUS_POLL_EN
  ,
  input  logic        cmd_poll,
  input  logic [15:0] cmd_mask
`endif
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  lbus_state_e      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             we_r;
  logic             repoll_s;

`ifdef LBUS_POLL_EN
  logic             poll_r;
  logic [15:0]      mask_r;
`endif

  // Decide at the end of GAP whether a polled read must run another bus cycle.
  always_comb begin
    repoll_s = 1'b0;
`ifdef LBUS_POLL_EN
    if (poll_r) begin
      repoll_s = poll_pending(rsp_rdata, mask_r);
    end else begin
      repoll_s = 1'b0;
    end
`endif
  end

  // Command FSM with inline phase counter; every output is a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      we_r      <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
      lbus_a    <= 16'h0000;
      lbus_di   <= 16'h0000;
      lbus_wr   <= 1'b0;
      lbus_rd   <= 1'b0;
`ifdef LBUS_POLL_EN
      poll_r    <= 1'b0;
      mask_r    <= 16'h0000;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            we_r      <= cmd_we;
            lbus_a    <= cmd_addr;
            lbus_di   <= cmd_we ? cmd_wdata : 16'h0000;
            rsp_rdata <= 16'h0000;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cnt_r     <= SETUP_LD;
            state_r   <= SETUP;
`ifdef LBUS_POLL_EN
            poll_r    <= cmd_poll && !cmd_we;
            mask_r    <= cmd_mask;
`endif
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            lbus_wr <= we_r;
            lbus_rd <= !we_r;
            cnt_r   <= STROBE_LD;
            state_r <= STROBE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        STROBE: begin
          if (cnt_r == CNT_ZERO) begin
            // The responder's registered data is valid by the last strobe cycle.
            if (!we_r) begin
              rsp_rdata <= lbus_do;
            end else begin
              rsp_rdata <= 16'h0000;
            end
            lbus_wr <= 1'b0;
            lbus_rd <= 1'b0;
            cnt_r   <= GAP_LD;
            state_r <= GAP;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        GAP: begin
          if (cnt_r == CNT_ZERO) begin
            if (repoll_s) begin
              cnt_r   <= SETUP_LD;
              state_r <= SETUP;
            end else begin
              rsp_valid <= 1'b1;
              cnt_r     <= CNT_ZERO;
              state_r   <= RESP;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            lbus_a    <= 16'h0000;
            lbus_di   <= 16'h0000;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            cnt_r     <= CNT_ZERO;
            state_r   <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end

        default: begin
          state_r   <= IDLE;
          cnt_r     <= CNT_ZERO;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          lbus_wr   <= 1'b0;
          lbus_rd   <= 1'b0;
          lbus_a    <= 16'h0000;
          lbus_di   <= 16'h0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_master.sv
// Directed bench for lbus_master with a registered responder model; the
// polled-read case is built only with LBUS_POLL_EN.
module tb_lbus_master;
  import lbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_addr = 16'h0000;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic [15:0] lbus_a;
  logic [15:0] lbus_di;
  logic        lbus_wr;
  logic        lbus_rd;
  logic [15:0] lbus_do = 16'h0000;
`ifdef LBUS_POLL_EN
  logic        cmd_poll = 1'b0;
  logic [15:0] cmd_mask = 16'h0000;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lbus_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .lbus_a(lbus_a), .lbus_di(lbus_di),
    .lbus_wr(lbus_wr), .lbus_rd(lbus_rd), .lbus_do(lbus_do)
`ifdef LBUS_POLL_EN
    , .cmd_poll(cmd_poll), .cmd_mask(cmd_mask)
`endif
  );

  // Responder model: registered read data, writes latched on a rising lbus_wr.
  logic [15:0] reg_ctrl = 16'h0000;
  logic [15:0] reg_din = 16'h0000;
  logic [15:0] reg_dout = 16'h0000;
  logic        wr_q = 1'b0;
  logic        rd_q = 1'b0;
  int          wr_edges = 0;
  int          rd_pulses = 0;
  logic        poll_mode = 1'b0;
  int          poll_left = 0;

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    case (a)
      ADDR_ID:   return 16'h4702;
      ADDR_CTRL: return poll_mode ? ((poll_left != 0) ? 16'h0001 : 16'h0000) : reg_ctrl;
      ADDR_DIN:  return reg_din;
      ADDR_DOUT: return reg_dout;
      default:   return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    wr_q    <= lbus_wr;
    rd_q    <= lbus_rd;
    lbus_do <= model_rd(lbus_a);
    if (lbus_wr && !wr_q) begin
      wr_edges <= wr_edges + 1;
      case (lbus_a)
        ADDR_CTRL: reg_ctrl <= lbus_di;
        ADDR_DIN:  reg_din  <= lbus_di;
        ADDR_DOUT: reg_dout <= lbus_di;
        default:   ;
      endcase
    end
    if (rd_q && !lbus_rd) begin
      rd_pulses <= rd_pulses + 1;
      if (poll_mode && poll_left > 0) poll_left <= poll_left - 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command from a negedge, record bus activity per cycle after
  // accept, optionally stall the response, then complete the handshake.
  task automatic run_cmd(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input int hold, output logic [15:0] rdata, output int lat,
                         output int waited, output logic [63:0] wmask, output logic [63:0] rmask,
                         output bit a_ok, output bit rdy_ok);
    logic [15:0] exp_di;
    exp_di = we ? wdata : 16'h0000;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = addr;
    cmd_wdata = wdata;
    waited = 0;
    while (!cmd_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; wmask = 64'd0; rmask = 64'd0; a_ok = 1'b1; rdy_ok = 1'b1; rdata = 16'h0000;
    for (int c = 1; c < 64; c++) begin
      if (rsp_valid) begin
        lat = c;
        break;
      end
      if (lbus_wr) wmask[c] = 1'b1;
      if (lbus_rd) rmask[c] = 1'b1;
      if (lbus_a !== addr || lbus_di !== exp_di || (lbus_wr && lbus_rd)) a_ok = 1'b0;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) rdy_ok = 1'b0;
      @(negedge clk);
    end
    if (lat != 0) begin
      rdata = rsp_rdata;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(rdata));
        chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("hold_bus_idle", 64'({lbus_wr, lbus_rd}), 64'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_lbus_a", 64'(lbus_a), 64'd0);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [15:0] rdata;
    int          lat, waited, e0, p0;
    logic [63:0] wmask, rmask;
    bit          a_ok, rdy_ok, saw_rsp;

    vecs[0] = '{1'b1, ADDR_DIN,  16'h0ABC, 16'h0000};
    vecs[1] = '{1'b0, ADDR_ID,   16'hFFFF, 16'h4702};
    vecs[2] = '{1'b1, ADDR_CTRL, 16'h0001, 16'h0000};
    vecs[3] = '{1'b0, ADDR_CTRL, 16'h0000, 16'h0001};
    vecs[4] = '{1'b0, ADDR_DIN,  16'h0000, 16'h0ABC};
    vecs[5] = '{1'b1, ADDR_DOUT, 16'h5A5A, 16'h0000};
    vecs[6] = '{1'b0, ADDR_DOUT, 16'h0000, 16'h5A5A};

    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_outputs", 64'({rsp_valid, busy, lbus_wr, lbus_rd}), 64'd0);
    chk("reset_bus", 64'({lbus_a, lbus_di, rsp_rdata}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive table entries run back-to-back with a single IDLE cycle.
    for (int i = 0; i < 7; i++) begin
      e0 = wr_edges;
      run_cmd(vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rdata, lat, waited, wmask, rmask, a_ok, rdy_ok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd9);
      chk($sformatf("v%0d_accept_wait", i), 64'(waited), 64'd0);
      chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_wr_cycles", i), wmask, vecs[i].we ? 64'h38 : 64'h0);
      chk($sformatf("v%0d_rd_cycles", i), rmask, vecs[i].we ? 64'h0 : 64'h38);
      chk($sformatf("v%0d_addr_data_hold", i), 64'(a_ok), 64'd1);
      chk($sformatf("v%0d_ready_low", i), 64'(rdy_ok), 64'd0 + 64'd1);
      chk($sformatf("v%0d_wr_edges", i), 64'(wr_edges - e0), vecs[i].we ? 64'd1 : 64'd0);
      if (vecs[i].we) chk($sformatf("v%0d_model_latch", i), 64'(model_rd(vecs[i].addr)), 64'(vecs[i].wdata));
    end

    // Response stalled for five cycles.
    run_cmd(1'b0, ADDR_ID, 16'h0000, 5, rdata, lat, waited, wmask, rmask, a_ok, rdy_ok);
    chk("stall_latency", 64'(lat), 64'd9);
    chk("stall_rdata", 64'(rdata), 64'h4702);

    // Reset on the second strobe cycle of a write.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = ADDR_DOUT; cmd_wdata = 16'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_wr", 64'(lbus_wr), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_wr_drop", 64'(lbus_wr), 64'd0);
    chk("rst_a_drop", 64'(lbus_a), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_rsp = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid || lbus_wr || lbus_rd) saw_rsp = 1'b1;
    end
    chk("rst_no_response", 64'(saw_rsp), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

`ifdef LBUS_POLL_EN
    poll_mode = 1'b1;
    poll_left = 3;
    cmd_poll = 1'b1;
    cmd_mask = 16'h0001;
    p0 = rd_pulses;
    run_cmd(1'b0, ADDR_CTRL, 16'h0000, 0, rdata, lat, waited, wmask, rmask, a_ok, rdy_ok);
    cmd_poll = 1'b0;
    poll_mode = 1'b0;
    chk("poll_latency", 64'(lat), 64'd33);
    chk("poll_rd_cycles", rmask, 64'h38383838);
    chk("poll_rd_pulses", 64'(rd_pulses - p0), 64'd4);
    chk("poll_rdata", 64'(rdata), 64'h0000);
    chk("poll_addr_hold", 64'(a_ok), 64'd1);
`else
    p0 = rd_pulses;
    run_cmd(1'b0, ADDR_CTRL, 16'h0000, 0, rdata, lat, waited, wmask, rmask, a_ok, rdy_ok);
    chk("single_rd_pulse", 64'(rd_pulses - p0), 64'd1);
    chk("single_rd_data", 64'(rdata), 64'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
